// File: rtl/mem_access_pkg.sv
// Shared encodings and lane helpers for the load/store controller.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOAD   = 3'd1;
  localparam state_t ST_RMW_RD = 3'd2;
  localparam state_t ST_WRITE  = 3'd3;
  localparam state_t ST_RESP   = 3'd4;

  // Pull the addressed byte/half out of a word and sign- or zero-extend it.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: lane_extract = uns ? {24'd0, b} : {{24{b[7]}}, b};
      SZ_HALF: lane_extract = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: lane_extract = word;
    endcase
  endfunction

  // Overlay right-aligned store data onto the addressed lane, other lanes kept.
  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  size,
                                             input logic [1:0]  off);
    logic [31:0] res;
    res = word;
    case (size)
      SZ_BYTE: res[{off, 3'b000} +: 8]     = wdata[7:0];
      SZ_HALF: res[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: res = wdata;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane extract/extend (loads) and lane merge (sub-word stores).
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        uns_i,
  input  logic [31:0] rd_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_data_o
);

  // Both paths see the same captured memory word; the FSM picks which it uses.
  always_comb begin
    ld_data_o = lane_extract(rd_i, size_i, off_i, uns_i);
    st_data_o = lane_merge(rd_i, wdata_i, size_i, off_i);
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller in front of a 32-bit word DataMem with combinational read.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] A,
  output logic [31:0]       WD,
  output logic              WE,
  input  logic [31:0]       RD
);

  state_t              state_q, state_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [1:0]          off_q, off_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [ADDR_W-1:0]   a_q, a_d;
  logic [31:0]         wd_q, wd_d;
  logic                wr_q, wr_d;
  logic                rvalid_q, rvalid_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                rerr_q, rerr_d;

  logic                addr_hi_set, misalign, acc_err;
  logic [31:0]         ld_data, st_data;

  mem_lane_align u_align (
    .size_i    (size_q),
    .off_i     (off_q),
    .uns_i     (uns_q),
    .rd_i      (RD),
    .wdata_i   (wdata_q),
    .ld_data_o (ld_data),
    .st_data_o (st_data)
  );

  // Fault classification of the incoming request, evaluated at accept.
  always_comb begin
    addr_hi_set = |(req_addr >> (ADDR_W + 2));
    misalign    = ((req_size == SZ_HALF) && req_addr[0]) ||
                  ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    acc_err     = (req_size == SZ_ILL) || misalign || addr_hi_set;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    size_d   = size_q;
    uns_d    = uns_q;
    off_d    = off_q;
    wdata_d  = wdata_q;
    a_d      = a_q;
    wd_d     = wd_q;
    wr_d     = 1'b0;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rerr_d   = rerr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          size_d  = req_size;
          uns_d   = req_unsigned;
          off_d   = req_addr[1:0];
          wdata_d = req_wdata;
          a_d     = req_addr[ADDR_W+1:2];
          rdata_d = '0;
          rerr_d  = 1'b0;
          if (acc_err) begin
            rerr_d   = 1'b1;
            rvalid_d = 1'b1;
            state_d  = ST_RESP;
          end else if (!req_we) begin
            state_d = ST_LOAD;
          end else if (req_size == SZ_WORD) begin
            wd_d    = req_wdata;
            wr_d    = 1'b1;
            state_d = ST_WRITE;
          end else begin
            state_d = ST_RMW_RD;
          end
        end
      end
      ST_LOAD: begin
        rdata_d  = ld_data;
        rvalid_d = 1'b1;
        state_d  = ST_RESP;
      end
      ST_RMW_RD: begin
        wd_d    = st_data;
        wr_d    = 1'b1;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        // Memory write lands on the edge that leaves this state.
        rvalid_d = 1'b1;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          rvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; async reset drops WE at once so an RMW in flight is abandoned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      size_q   <= '0;
      uns_q    <= 1'b0;
      off_q    <= '0;
      wdata_q  <= '0;
      a_q      <= '0;
      wd_q     <= '0;
      wr_q     <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      off_q    <= off_d;
      wdata_q  <= wdata_d;
      a_q      <= a_d;
      wd_q     <= wd_d;
      wr_q     <= wr_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE) && !rst;
  assign resp_valid = rvalid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = rerr_q;
  assign A          = a_q;
  assign WD         = wd_q;
  assign WE         = wr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: DataMem model plus a byte-array reference of memory contents.
module tb_mem_access_ctrl;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [4:0]  A;
  logic [31:0] WD, RD;
  logic        WE;

  logic [31:0] mem [32];
  logic        pre_en;
  logic [4:0]  pre_a;
  logic [31:0] pre_d;

  logic [7:0]  rb [128];
  int          errors = 0;
  int          checks = 0;

  mem_access_ctrl #(.ADDR_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .A            (A),
    .WD           (WD),
    .WE           (WE),
    .RD           (RD)
  );

  // DataMem: combinational read, synchronous write; preload port used only under reset.
  assign RD = mem[A];
  always @(posedge clk) begin
    if (pre_en) mem[pre_a] <= pre_d;
    else if (WE) mem[A] <= WD;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {rb[4*w+3], rb[4*w+2], rb[4*w+1], rb[4*w]};
  endfunction

  function automatic bit ref_err(input logic [1:0] sz, input logic [31:0] addr);
    if (sz == 2'b11) return 1'b1;
    if (addr >= 32'd128) return 1'b1;
    if (sz == 2'b01 && (addr % 2) != 0) return 1'b1;
    if (sz == 2'b10 && (addr % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  // One full transaction with all observable checks; returns load data and WD seen.
  task automatic txn(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata, input int stall,
                     output logic [31:0] rd, output logic [31:0] wd_seen);
    bit          err;
    int          nbytes, exp_lat, cyc, we_cnt;
    logic [31:0] exp_rd, exp_word, held;
    logic [4:0]  a_seen;
    err     = ref_err(sz, addr);
    nbytes  = 1 << sz;
    exp_rd  = 32'd0;
    wd_seen = 32'd0;
    a_seen  = 5'd0;
    if (!err && !we) begin
      for (int i = 0; i < nbytes; i++) exp_rd[8*i +: 8] = rb[addr + i];
      if (!uns && nbytes < 4 && exp_rd[8*nbytes-1])
        for (int i = nbytes; i < 4; i++) exp_rd[8*i +: 8] = 8'hFF;
    end
    if (!err && we)
      for (int i = 0; i < nbytes; i++) rb[addr + i] = wdata[8*i +: 8];
    exp_lat = err ? 1 : (!we ? 2 : (nbytes == 4 ? 2 : 3));
    exp_word = err ? 32'd0 : ref_word(int'(addr[6:2]));

    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1; we_cnt = 0;
    while (!resp_valid && cyc < 8) begin
      if (WE) begin we_cnt++; wd_seen = WD; a_seen = A; end
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_lat"}, cyc, exp_lat);
    chk({tag, "_err"}, {31'd0, resp_err}, {31'd0, err});
    chk({tag, "_rdata"}, resp_rdata, exp_rd);
    rd = resp_rdata;
    held = resp_rdata;
    for (int s = 0; s < stall; s++) begin
      if (WE) we_cnt++;
      @(posedge clk); #1;
      chk({tag, "_hold_v"}, {31'd0, resp_valid}, 32'd1);
      chk({tag, "_hold_d"}, resp_rdata, held);
    end
    if (WE) we_cnt++;
    chk({tag, "_we_cnt"}, we_cnt, (we && !err) ? 1 : 0);
    if (we && !err) begin
      chk({tag, "_wd"}, wd_seen, exp_word);
      chk({tag, "_a"}, {27'd0, a_seen}, {27'd0, addr[6:2]});
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({tag, "_vdrop"}, {31'd0, resp_valid}, 32'd0);
    if (addr < 32'd128) chk({tag, "_mem"}, mem[addr[6:2]], ref_word(int'(addr[6:2])));
  endtask

  initial begin
    logic [31:0] rd, wds, held, w3;
    logic [31:0] ra;
    logic [1:0]  rs;
    req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0; resp_ready = 0;
    pre_en = 0; pre_a = 0; pre_d = 0;
    rst = 1'b1;

    // Preload memory under reset and mirror it into the byte reference.
    for (int i = 0; i < 32; i++) begin
      pre_en = 1'b1; pre_a = 5'(i); pre_d = $urandom;
      for (int b = 0; b < 4; b++) rb[4*i + b] = pre_d[8*b +: 8];
      @(posedge clk); #1;
    end
    pre_en = 1'b0;
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_we", {31'd0, WE}, 32'd0);
    chk("rst_a", {27'd0, A}, 32'd0);
    chk("rst_wd", WD, 32'd0);
    chk("rst_rv", {31'd0, resp_valid}, 32'd0);
    chk("rst_rd", resp_rdata, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: word store then word load
    txn("t1_st", 1, 2'b10, 0, 32'h0C, 32'hDEADBEEF, 0, rd, wds);
    chk("t1_wd_const", wds, 32'hDEADBEEF);
    txn("t1_ld", 0, 2'b10, 0, 32'h0C, 0, 0, rd, wds);
    chk("t1_ld_const", rd, 32'hDEADBEEF);

    // 2: sub-word loads of 0x80FF7F01
    txn("t2_st", 1, 2'b10, 0, 32'h0C, 32'h80FF7F01, 0, rd, wds);
    txn("t2_b0f_s", 0, 2'b00, 0, 32'h0F, 0, 0, rd, wds);
    chk("t2_b0f_s_const", rd, 32'hFFFFFF80);
    txn("t2_b0f_u", 0, 2'b00, 1, 32'h0F, 0, 0, rd, wds);
    chk("t2_b0f_u_const", rd, 32'h00000080);
    txn("t2_h0e_s", 0, 2'b01, 0, 32'h0E, 0, 0, rd, wds);
    chk("t2_h0e_s_const", rd, 32'hFFFF80FF);
    txn("t2_b0c_s", 0, 2'b00, 0, 32'h0C, 0, 0, rd, wds);
    chk("t2_b0c_s_const", rd, 32'h00000001);

    // 3: read-modify-write stores into 0x11223344
    txn("t3_st", 1, 2'b10, 0, 32'h0C, 32'h11223344, 0, rd, wds);
    txn("t3_b0d", 1, 2'b00, 0, 32'h0D, 32'hFFFFFFAB, 0, rd, wds);
    chk("t3_b0d_wd_const", wds, 32'h1122AB44);
    txn("t3_h0e", 1, 2'b01, 0, 32'h0E, 32'h1234CAFE, 0, rd, wds);
    txn("t3_ld", 0, 2'b10, 0, 32'h0C, 0, 0, rd, wds);
    chk("t3_ld_const", rd, 32'hCAFEAB44);

    // 4: faulting accesses leave word 3 untouched
    txn("t4_h0d", 1, 2'b01, 0, 32'h0D, 32'h0, 0, rd, wds);
    txn("t4_w0e", 1, 2'b10, 0, 32'h0E, 32'h0, 0, rd, wds);
    txn("t4_b80", 1, 2'b00, 0, 32'h80, 32'h0, 0, rd, wds);
    txn("t4_ill", 1, 2'b11, 0, 32'h00, 32'h0, 0, rd, wds);
    chk("t4_w3_const", mem[3], 32'hCAFEAB44);

    // 5: response backpressure with a competing request held on the bus
    req_valid = 1; req_we = 0; req_size = 2'b10; req_unsigned = 0; req_addr = 32'h0C;
    @(posedge clk); #1;
    req_we = 1; req_addr = 32'h14; req_wdata = 32'h5555AAAA;
    @(posedge clk); #1;
    chk("t5_rv", {31'd0, resp_valid}, 32'd1);
    chk("t5_rd", resp_rdata, ref_word(3));
    held = resp_rdata;
    for (int s = 0; s < 3; s++) begin
      chk("t5_stall_ready", {31'd0, req_ready}, 32'd0);
      chk("t5_stall_rv", {31'd0, resp_valid}, 32'd1);
      chk("t5_stall_rd", resp_rdata, held);
      chk("t5_stall_we", {31'd0, WE}, 32'd0);
      @(posedge clk); #1;
    end
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;
    chk("t5_idle_we", {31'd0, WE}, 32'd0);
    chk("t5_mem5_pre", mem[5], ref_word(5));
    txn("t5_second", 1, 2'b10, 0, 32'h14, 32'h5555AAAA, 0, rd, wds);

    // 6: reset during the WRITE cycle of a byte store
    w3 = ref_word(3);
    req_valid = 1; req_we = 1; req_size = 2'b00; req_addr = 32'h0D; req_wdata = 32'h77;
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #1;
    chk("t6_we_before", {31'd0, WE}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_we", {31'd0, WE}, 32'd0);
    chk("t6_rv", {31'd0, resp_valid}, 32'd0);
    chk("t6_a", {27'd0, A}, 32'd0);
    chk("t6_wd", WD, 32'd0);
    chk("t6_ready_rst", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_ready", {31'd0, req_ready}, 32'd1);
    chk("t6_mem3", mem[3], w3);
    @(posedge clk); #1;

    // Randomized traffic against the byte-array reference
    for (int n = 0; n < 200; n++) begin
      rs = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      ra = $urandom_range(0, 127);
      if ($urandom_range(0, 7) == 0) ra = ra | (32'd1 << $urandom_range(7, 31));
      else if (rs == 2'b01 && $urandom_range(0, 3) != 0) ra[0] = 1'b0;
      else if (rs == 2'b10 && $urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
      txn("rnd", 1'($urandom_range(0, 1)), rs, 1'($urandom_range(0, 1)), ra, $urandom,
          $urandom_range(0, 2), rd, wds);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Load/store controller sitting directly upstream of DataMem (32 x 32-bit words, combinational read on A, synchronous write on clk when WE). Accepts byte/half/word load and store requests from the execute stage over a valid/ready handshake. Drives DataMem's A/WD/WE and does read-modify-write for sub-word stores. Returns extended load data, or an error for misaligned, out-of-range or illegal-size accesses, over a valid/ready response channel.

Parameters:
ADDR_W, 5, DataMem word-address width; memory span = 4<<ADDR_W bytes (128 by default)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  input  1  request present
req_ready  output  1  controller can accept (state IDLE and rst low)
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts response
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  access faulted; no memory write occurred
A  output  ADDR_W  DataMem word address
WD  output  32  DataMem write data
WE  output  1  DataMem write enable
RD  input  32  DataMem read data (combinational from A)

Behaviour:
- Reset (async, immediate): state IDLE; A=0, WD=0, WE=0, resp_valid=0, resp_rdata=0, resp_err=0, all latches cleared. req_ready=0 while rst is high.
- A, WD, WE, resp_* are registered. WE is high only in state WRITE.
- Accept: req_valid & req_ready at a rising edge (cycle 0). Latch we/size/unsigned/addr/wdata. A <= req_addr[ADDR_W+1:2].
- Error check at accept:
  - size==11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - any bit of addr[31:ADDR_W+2] set.
  - On error: next state RESP with resp_err=1, resp_rdata=0. WE is never asserted.
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
  - Load: IDLE -> LOAD (cycle 1). Extract lane from RD: byte lane = addr[1:0]; half lane = addr[1]. Extend per req_unsigned and register into resp_rdata -> RESP. resp_valid first high in cycle 2.
  - Word store: IDLE -> WRITE (cycle 1: WD=wdata, WE=1; the memory write happens at the edge that ends cycle 1) -> RESP. resp_valid first high in cycle 2.
  - Sub-word store: IDLE -> RMW_RD (cycle 1). Capture RD and merge wdata[7:0] or wdata[15:0] into the addressed lane, other lanes kept, into WD. Then -> WRITE (cycle 2) -> RESP. resp_valid first high in cycle 3.
  - RESP: resp_valid=1. Outputs are held stable until resp_ready; then -> IDLE, resp_valid=0. The next request can be accepted on the cycle after the response handshake.
- req_valid outside IDLE is ignored and not latched.
- Store responses return resp_rdata=0, resp_err=0.
- Reset mid-operation: WE drops immediately. A partially complete RMW is abandoned and the memory word keeps its prior value unless the write edge has already occurred.

Decomposition:
- Package mem_access_pkg: size encodings (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10), state enum, a function for lane extract/extend and a function for lane merge.
- One sub-module is natural: mem_lane_align (combinational extract/extend and merge by size/offset), reused by both LOAD and RMW_RD.

Test Plan:
1. Word store addr 0x0C data 0xDEADBEEF, then word load 0x0C -> WE high exactly 1 cycle with A=3, WD=0xDEADBEEF; store resp in cycle 2 (err=0, rdata=0); load resp in cycle 2, rdata=0xDEADBEEF.
2. Word 3 = 0x80FF7F01:
   - byte load 0x0F signed -> 0xFFFFFF80; unsigned -> 0x00000080;
   - half load 0x0E signed -> 0xFFFF80FF;
   - byte load 0x0C signed -> 0x00000001.
3. Word 3 = 0x11223344:
   - byte store 0xAB to 0x0D -> WD=0x1122AB44 in cycle 2, resp in cycle 3;
   - half store 0xCAFE to 0x0E -> next load 0x0C = 0xCAFEAB44.
4. Half at 0x0D, word at 0x0E, byte at 0x80, size 11 at 0x00 -> resp_err=1 and resp_rdata=0 in cycle 1; WE never high; word 3 unchanged.
5. Load with resp_ready low for 3 cycles, req_valid held high with another request -> resp_valid/rdata stable, req_ready=0, second request not accepted until after the handshake.
6. Assert rst in cycle 2 of a byte store (WRITE) -> WE, resp_valid, A, WD read 0 immediately; state IDLE; req_ready=1 on the first cycle after rst falls.
